alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised execute-stage unit that merges ALU control decode (`alu_op` plus R-type `funct`) with a WIDTH-bit datapath. It extends the single-cycle operation set with multi-cycle unsigned multiply and divide, HI/LO registers and valid/ready handshakes. It sits between the ID/EX register and the EX/MEM register and back-pressures issue while an iterative operation runs.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 4 and even.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `alu_op`  in  2  0 = add, 1 = sub, 2 = decode `funct`, 3 = illegal.
- `funct`  in  6  R-type function code; ignored unless `alu_op` = 2.
- `a`, `b`  in  WIDTH  operands (rs, rt).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result` == 0; registered with `result`.
- `illegal`  out  1  undecodable operation; registered with `result`.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- Accept on `in_valid && in_ready`.
- `funct` decode: 32/33 add, 34/35 sub, 36 and, 37 or, 38 xor, 39 nor, 42 slt (signed), 43 sltu, 16 mfhi, 18 mflo, 25 multu, 27 divu.
- Add/sub wrap modulo 2^WIDTH; no overflow trap. slt/sltu produce 1 or 0 zero-extended.
- multu: {hi, lo} ← a × b (2·WIDTH-bit unsigned product). `result` = low half.
- divu: lo ← a / b, hi ← a % b. `result` = quotient.
- divu with b = 0: lo ← all ones, hi ← a, `result` = all ones. Completes in single-cycle latency and sets no flag.
- Any other `funct`, or `alu_op` = 3: `result` = 0, `illegal` = 1. hi/lo unchanged.
- hi/lo change only on multu/divu completion.
- State machine:
  - IDLE: on accept, single-cycle ops and divu-by-0 go to DONE; multu goes to MUL; divu goes to DIV.
  - MUL: shift-add. DIV: restoring shift-subtract. Each runs a counter WIDTH→0, one bit per cycle, then goes to DONE.
  - DONE: `out_valid` = 1, outputs held stable. On `out_ready`, go to IDLE.
- Reset values: state IDLE, `in_ready` 1 (combinational from state), `out_valid` 0, `result` 0, `zero` 1, `illegal` 0, `hi` 0, `lo` 0, counter 0.

## Timing
- Acceptance in cycle N.
- Single-cycle ops: `out_valid` rises in cycle N+1.
- multu/divu: `out_valid` in cycle N+WIDTH+1; hi/lo update at that same edge.
- `in_ready` is low from cycle N+1 until the cycle after the `out_valid && out_ready` handshake. The unit never overlaps operations, so throughput is at most one result per 2 cycles.
- `out_ready` held low: outputs and state frozen indefinitely.
- `out_ready` asserted before `out_valid`: has no effect.
- mfhi/mflo accepted right after a multu completes read the updated hi/lo.
- `rst` mid-MUL/DIV: aborts the operation; hi/lo are cleared, not partially written. All outputs take reset values at the next edge.
- `rst` has priority over a simultaneous accept or handshake.
- `in_valid` deasserted while `in_ready` = 0 is legal; nothing is captured.

## Structure
- Shared package `alu_pkg`:
  - `alu_op` encodings, funct code constants, operation enum.
  - State enum {IDLE, MUL, DIV, DONE}.
  - WIDTH-independent decode function `alu_decode(alu_op, funct)` returning an operation enum plus an illegal bit, reused by the hazard unit.
- One sub-module, `seq_muldiv`: the iterative WIDTH-cycle multiplier/divider.
  - Inputs: start, is_div, a, b.
  - Outputs: done, hi_q, lo_q.
  - Owns the bit counter.
- Top-level owns decode, single-cycle datapath, handshake FSM and HI/LO.

## Test plan
- WIDTH=32, `alu_op`=2, `funct`=34, a=5, b=7 → cycle N+1: `result`=0xFFFFFFFE, `zero`=0, `illegal`=0. `funct`=43 with the same operands → `result`=1; `funct`=42 with a=0xFFFFFFFF, b=1 → `result`=1.
- multu a=0xFFFFFFFF, b=2 → `in_ready` low for 33 cycles; at N+33 `hi`=1, `lo`=0xFFFFFFFE, `result`=0xFFFFFFFE. A following mflo returns 0xFFFFFFFE.
- divu a=100, b=7 → N+33: `lo`=14, `hi`=2. divu a=9, b=0 → N+1: `lo`=0xFFFFFFFF, `hi`=9.
- `out_ready` held low 10 cycles after an add result → `result`/`out_valid` stable, `in_ready`=0. Release → `in_ready`=1 the next cycle.
- `rst` asserted 5 cycles into multu → next cycle state IDLE, `hi`=`lo`=0, `out_valid`=0. A subsequent add 3+4 returns 7.
- `alu_op`=2, `funct`=0x3F, then `alu_op`=3 → `illegal`=1, `result`=0, hi/lo unchanged. Repeat with WIDTH=8 on multu 0xFF×0xFF → `hi`=0xFE, `lo`=0x01 at N+9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared decode definitions for the execute-stage ALU: alu_op/funct encodings,
// operation set, FSM state codes and the WIDTH-independent control decode.
package alu_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;
   localparam logic [1:0] ALUOP_ILL   = 2'd3;

   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_ADDU  = 6'd33;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_SUBU  = 6'd35;
   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_XOR   = 6'd38;
   localparam logic [5:0] F_NOR   = 6'd39;
   localparam logic [5:0] F_SLT   = 6'd42;
   localparam logic [5:0] F_SLTU  = 6'd43;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
      OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU, OP_ILL
   } op_e;

   typedef struct packed {
      op_e  op;
      logic illegal;
   } dec_t;

   function automatic dec_t alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
      dec_t d;
      d.op      = OP_ILL;
      d.illegal = 1'b1;
      case (alu_op)
         ALUOP_ADD: begin d.op = OP_ADD; d.illegal = 1'b0; end
         ALUOP_SUB: begin d.op = OP_SUB; d.illegal = 1'b0; end
         ALUOP_FUNCT: begin
            d.illegal = 1'b0;
            case (funct)
               F_ADD, F_ADDU: d.op = OP_ADD;
               F_SUB, F_SUBU: d.op = OP_SUB;
               F_AND:         d.op = OP_AND;
               F_OR:          d.op = OP_OR;
               F_XOR:         d.op = OP_XOR;
               F_NOR:         d.op = OP_NOR;
               F_SLT:         d.op = OP_SLT;
               F_SLTU:        d.op = OP_SLTU;
               F_MFHI:        d.op = OP_MFHI;
               F_MFLO:        d.op = OP_MFLO;
               F_MULTU:       d.op = OP_MULTU;
               F_DIVU:        d.op = OP_DIVU;
               default: begin d.op = OP_ILL; d.illegal = 1'b1; end
            endcase
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_exec_unit_seq_muldiv.sv
// Iterative unsigned multiplier (shift-add) / divider (restoring), one bit per
// cycle. The first step is folded into the start cycle so done rises WIDTH cycles later.
module seq_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi_q,
   output logic [WIDTH-1:0] lo_q
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] hi_d, lo_d, m_q, m_d;
   logic [WIDTH-1:0] acc_in, q_in, m_in, hi_step, lo_step;
   logic [WIDTH:0]   sum, shifted, diff;
   logic             div_q, div_d, div_in, busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      acc_in  = start ? '0 : hi_q;
      q_in    = start ? a  : lo_q;
      m_in    = start ? b  : m_q;
      div_in  = start ? is_div : div_q;
      sum     = {1'b0, acc_in} + (q_in[0] ? {1'b0, m_in} : '0);
      shifted = {acc_in, q_in[WIDTH-1]};
      diff    = shifted - {1'b0, m_in};
      // remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag
      if (div_in) begin
         hi_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
         lo_step = {q_in[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
         hi_step = sum[WIDTH:1];
         lo_step = {sum[0], q_in[WIDTH-1:1]};
      end

      hi_d   = hi_q;
      lo_d   = lo_q;
      m_d    = m_q;
      div_d  = div_q;
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (start) begin
         hi_d   = hi_step;
         lo_d   = lo_step;
         m_d    = b;
         div_d  = is_div;
         busy_d = 1'b1;
         cnt_d  = CNT_LAST;
      end else if (busy_q) begin
         if (cnt_q != '0) begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q - CW'(1);
         end else begin
            busy_d = 1'b0;
         end
      end
   end

   assign done = busy_q && (cnt_q == '0) && !start;

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         m_q    <= '0;
         div_q  <= 1'b0;
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         m_q    <= m_d;
         div_q  <= div_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage unit: decode, single-cycle datapath, HI/LO and a valid/ready FSM
// that stalls issue while the iterative multiplier/divider runs.
//  state   | meaning
//  IDLE    | in_ready high, waiting for an operation
//  MUL/DIV | iterative multu/divu in progress
//  DONE    | out_valid high, result held until out_ready
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d, alu_res;
   logic [WIDTH-1:0] md_hi, md_lo;
   logic             zero_q, zero_d, illegal_q, illegal_d;
   logic             accept, b_zero, md_start, md_done;
   dec_t             dec;

   assign dec      = alu_decode(alu_op, funct);
   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign b_zero   = (b == '0);
   assign md_start = accept && ((dec.op == OP_MULTU) || (dec.op == OP_DIVU && !b_zero));

   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .is_div (dec.op == OP_DIVU),
      .a      (a),
      .b      (b),
      .done   (md_done),
      .hi_q   (md_hi),
      .lo_q   (md_lo)
   );

   always_comb begin
      case (dec.op)
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         OP_DIVU: alu_res = '1;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (dec.op == OP_MULTU) begin
                  state_d = ST_MUL;
               end else if (dec.op == OP_DIVU && !b_zero) begin
                  state_d = ST_DIV;
               end else begin
                  state_d   = ST_DONE;
                  result_d  = alu_res;
                  zero_d    = (alu_res == '0);
                  illegal_d = dec.illegal;
                  // divide by zero completes immediately with a defined HI/LO
                  if (dec.op == OP_DIVU) begin
                     hi_d = a;
                     lo_d = '1;
                  end
               end
            end
         end
         ST_MUL, ST_DIV: begin
            if (md_done) begin
               state_d   = ST_DONE;
               result_d  = md_lo;
               zero_d    = (md_lo == '0);
               illegal_d = 1'b0;
               hi_d      = md_hi;
               lo_d      = md_lo;
            end
         end
         default: begin
            if (out_ready) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a behavioural model queues expected
// results at issue; they are popped and compared when out_valid appears.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, zero, illegal;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] a, b, result, hi, lo;

   logic       n_in_valid, n_in_ready, n_out_valid, n_zero, n_illegal;
   logic [1:0] n_alu_op;
   logic [5:0] n_funct;
   logic [7:0] n_a, n_b, n_result, n_hi, n_lo;

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct(funct), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .illegal(illegal), .hi(hi), .lo(lo)
   );

   alu_exec_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
      .alu_op(n_alu_op), .funct(n_funct), .a(n_a), .b(n_b),
      .out_valid(n_out_valid), .out_ready(1'b1), .result(n_result),
      .zero(n_zero), .illegal(n_illegal), .hi(n_hi), .lo(n_lo)
   );

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ill;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // issue one op, wait for its result, optionally stall the consumer for hold cycles
   task automatic do_op(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] x, input logic [31:0] y, input int hold);
      exp_t        e, g;
      logic [63:0] p;
      logic [31:0] r0;
      int          n;
      e.hi = m_hi; e.lo = m_lo; e.ill = 1'b0; e.lat = 1; e.res = '0;
      if (op == 2'd0)      e.res = x + y;
      else if (op == 2'd1) e.res = x - y;
      else if (op == 2'd3) e.ill = 1'b1;
      else begin
         case (f)
            6'd32, 6'd33: e.res = x + y;
            6'd34, 6'd35: e.res = x - y;
            6'd36: e.res = x & y;
            6'd37: e.res = x | y;
            6'd38: e.res = x ^ y;
            6'd39: e.res = ~(x | y);
            6'd42: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            6'd43: e.res = (x < y) ? 32'd1 : 32'd0;
            6'd16: e.res = m_hi;
            6'd18: e.res = m_lo;
            6'd25: begin
               p = {32'd0, x} * {32'd0, y};
               e.hi = p[63:32]; e.lo = p[31:0]; e.res = p[31:0]; e.lat = 33;
            end
            6'd27: begin
               if (y == 0) begin
                  e.hi = x; e.lo = '1; e.res = '1;
               end else begin
                  e.hi = x % y; e.lo = x / y; e.res = x / y; e.lat = 33;
               end
            end
            default: e.ill = 1'b1;
         endcase
      end
      e.zero = (e.res == 0);
      m_hi = e.hi;
      m_lo = e.lo;
      sb.push_back(e);

      @(negedge clk);
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) chk("ready_wait", {63'd0, in_ready}, 64'd1);
      alu_op = op; funct = f; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      n = 1;
      @(negedge clk);
      chk("busy_rdy", {63'd0, in_ready}, 64'd0);
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      g = sb.pop_front();
      chk("latency", n, g.lat);
      chk("result", result, g.res);
      chk("zero", {63'd0, zero}, {63'd0, g.zero});
      chk("illegal", {63'd0, illegal}, {63'd0, g.ill});
      chk("hi", hi, g.hi);
      chk("lo", lo, g.lo);
      if (hold > 0) begin
         r0 = g.res;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_res", result, r0);
            chk("hold_vld_rdy", {62'd0, out_valid, in_ready}, 64'd2);
         end
         out_ready = 1'b1;
      end
      @(negedge clk);
      chk("rdy_after", {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      logic [5:0] fl[8];
      int         n;
      fl = '{6'd32, 6'd35, 6'd36, 6'd38, 6'd39, 6'd42, 6'd25, 6'd27};
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      alu_op = '0; funct = '0; a = '0; b = '0;
      n_in_valid = 1'b0; n_alu_op = '0; n_funct = '0; n_a = '0; n_b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
      chk("rst_result", result, 32'd0);
      chk("rst_zero_ill", {62'd0, zero, illegal}, 64'd2);
      chk("rst_hilo", {hi, lo}, 64'd0);

      do_op(2'd2, 6'd34, 32'd5, 32'd7, 0);
      do_op(2'd2, 6'd43, 32'd5, 32'd7, 0);
      do_op(2'd2, 6'd42, 32'hFFFF_FFFF, 32'd1, 0);
      do_op(2'd0, 6'd0, 32'd1, 32'hFFFF_FFFF, 0);
      do_op(2'd1, 6'd0, 32'd10, 32'd3, 0);
      do_op(2'd2, 6'd37, 32'hF0F0_0000, 32'h0000_0F0F, 0);
      do_op(2'd2, 6'd25, 32'hFFFF_FFFF, 32'd2, 0);
      do_op(2'd2, 6'd18, 32'd0, 32'd0, 0);
      do_op(2'd2, 6'd16, 32'd0, 32'd0, 0);
      do_op(2'd2, 6'd27, 32'd100, 32'd7, 0);
      do_op(2'd2, 6'd16, 32'd0, 32'd0, 0);
      do_op(2'd2, 6'd27, 32'd9, 32'd0, 0);
      do_op(2'd2, 6'h3F, 32'd1, 32'd2, 0);
      do_op(2'd3, 6'd32, 32'd1, 32'd2, 0);
      out_ready = 1'b0;
      do_op(2'd0, 6'd0, 32'd20, 32'd22, 10);

      for (int i = 0; i < 8; i++)
         do_op(2'd2, fl[$urandom_range(0, 7)], $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom, 0);

      // abort a multiply with reset partway through
      @(negedge clk);
      alu_op = 2'd2; funct = 6'd25; a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
      chk("abort_hilo", {hi, lo}, 64'd0);
      m_hi = '0; m_lo = '0;
      do_op(2'd0, 6'd0, 32'd3, 32'd4, 0);
      do_op(2'd2, 6'd16, 32'd0, 32'd0, 0);

      @(negedge clk);
      n_alu_op = 2'd2; n_funct = 6'd25; n_a = 8'hFF; n_b = 8'hFF; n_in_valid = 1'b1;
      @(posedge clk);
      #1 n_in_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!n_out_valid && n < 100) begin @(negedge clk); n++; end
      chk("w8_latency", n, 9);
      chk("w8_hilo", {n_hi, n_lo}, 16'hFE01);
      chk("w8_result", n_result, 8'h01);
      chk("w8_flags", {n_zero, n_illegal}, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
